// File: rtl/check_level_pkg.sv
// Shared types and constants for the sequencer command blocks (check_level,
// set_injector, wait_event).
package tb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        DONE
    } check_state_t;

    localparam string CHECK_CMD = "CHECK_LEVEL";

    localparam int ARG_CMD   = 0;
    localparam int ARG_ALIAS = 1;
    localparam int ARG_VAL   = 2;
    localparam int ARG_MASK  = 3;

    // Index width for a table of n entries; a single-entry table still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/check_level_if.sv
// Command/ack bundle between the sequencer decoder (master) and the
// CHECK_LEVEL checker (slave).
interface check_level_if #(
    parameter int ARGS_NB   = 5,
    parameter int ERR_CNT_W = 16
);
    logic                 i_sel_check;
    logic                 i_args_valid;
    string                i_args [ARGS_NB];
    logic                 o_check_done;
    logic                 o_check_ok;
    logic                 o_busy;
    logic [ERR_CNT_W-1:0] o_err_cnt;

    modport master (
        output i_sel_check, i_args_valid, i_args,
        input  o_check_done, o_check_ok, o_busy, o_err_cnt
    );

    modport slave (
        input  i_sel_check, i_args_valid, i_args,
        output o_check_done, o_check_ok, o_busy, o_err_cnt
    );
endinterface

// File: rtl/check_level_alias_lookup.sv
// Combinational alias table search: the lowest index whose name equals the key wins.
module alias_lookup #(
    parameter int SIZE  = 5,
    parameter int IDX_W = 3
) (
    input  string             aliases [SIZE],
    input  string             key,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (!found && (aliases[i] == key)) begin
                idx   = i[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/check_level.sv
// CHECK_LEVEL command executor: alias lookup, one-edge level sample, compare, ack.
// Optional masked compare is enabled by defining CHECK_LEVEL_MASK_EN.
module check_level
    import tb_seq_pkg::*;
#(
    parameter int ARGS_NB     = 5,
    parameter int CHECK_SIZE  = 5,
    parameter int CHECK_WIDTH = 32,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  string                  i_check_alias [CHECK_SIZE],
    input  logic [CHECK_WIDTH-1:0] i_check       [CHECK_SIZE],
    check_level_if.slave           bus
);
    localparam int IDX_W   = idx_width(CHECK_SIZE);
    localparam int PARSE_W = (CHECK_WIDTH > 64) ? CHECK_WIDTH : 64;

    function automatic logic parse_hex(input string s, output logic [CHECK_WIDTH-1:0] v);
        logic [PARSE_W-1:0] raw;
        int                 n;
        raw = '0;
        n   = $sscanf(s, "%h", raw);
        v   = raw[CHECK_WIDTH-1:0];
        return n == 1;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

`ifdef CHECK_LEVEL_MASK_EN
    // X/Z on masked-off bits vanish through the AND; anything left compares case-exact.
    function automatic logic level_match(input logic [CHECK_WIDTH-1:0] s, e, m);
        return ((s ^ e) & m) === '0;
    endfunction
`else
    function automatic logic level_match(input logic [CHECK_WIDTH-1:0] s, e);
        return s === e;
    endfunction
`endif

    string                  args [ARGS_NB];
    logic [CHECK_WIDTH-1:0] val_c;
    logic                   val_ok_c;
`ifdef CHECK_LEVEL_MASK_EN
    logic [CHECK_WIDTH-1:0] mask_raw_c;
    logic [CHECK_WIDTH-1:0] mask_c;
    logic                   mask_ok_c;
`endif

    always_comb begin
        for (int i = 0; i < ARGS_NB; i++) args[i] = bus.i_args[i];
        val_c    = '0;
        val_ok_c = parse_hex(args[ARG_VAL], val_c);
`ifdef CHECK_LEVEL_MASK_EN
        mask_raw_c = '0;
        mask_ok_c  = parse_hex(args[ARG_MASK], mask_raw_c);
        mask_c     = mask_ok_c ? mask_raw_c : '1;
`endif
    end

    check_state_t           state_q;
    string                  alias_p0;
    logic [CHECK_WIDTH-1:0] exp_p0;
    logic                   parse_err_p0;
`ifdef CHECK_LEVEL_MASK_EN
    logic [CHECK_WIDTH-1:0] mask_p0;
`endif
    logic [IDX_W-1:0]       idx_p1;
    logic                   found_p1;
    logic                   pass_p2;
    logic                   done_q;
    logic                   ok_q;
    logic                   busy_q;
    logic [ERR_CNT_W-1:0]   err_q;

    logic [IDX_W-1:0]       idx_c;
    logic                   found_c;

    alias_lookup #(
        .SIZE  (CHECK_SIZE),
        .IDX_W (IDX_W)
    ) u_lookup (
        .aliases (i_check_alias),
        .key     (alias_p0),
        .idx     (idx_c),
        .found   (found_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alias_p0     <= "";
            exp_p0       <= '0;
            parse_err_p0 <= 1'b0;
`ifdef CHECK_LEVEL_MASK_EN
            mask_p0      <= '1;
`endif
            idx_p1       <= '0;
            found_p1     <= 1'b0;
            pass_p2      <= 1'b0;
            done_q       <= 1'b0;
            ok_q         <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // stage 0: capture the command; busy stays high one IDLE edge after done
                IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.i_args_valid && bus.i_sel_check && !busy_q) begin
                        alias_p0     <= args[ARG_ALIAS];
                        exp_p0       <= val_c;
                        parse_err_p0 <= !val_ok_c;
`ifdef CHECK_LEVEL_MASK_EN
                        mask_p0      <= mask_c;
`endif
                        busy_q       <= 1'b1;
                        state_q      <= LOOKUP;
                    end
                end
                // stage 1: resolve alias to table index
                LOOKUP: begin
                    idx_p1   <= idx_c;
                    found_p1 <= found_c;
                    state_q  <= COMPARE;
                end
                // stage 2: the only edge on which the live level is sampled
                COMPARE: begin
`ifdef CHECK_LEVEL_MASK_EN
                    pass_p2 <= found_p1 && !parse_err_p0 &&
                               level_match(i_check[idx_p1], exp_p0, mask_p0);
`else
                    pass_p2 <= found_p1 && !parse_err_p0 &&
                               level_match(i_check[idx_p1], exp_p0);
`endif
                    state_q <= DONE;
                end
                // stage 3: ack pulse and status
                DONE: begin
                    done_q  <= 1'b1;
                    ok_q    <= pass_p2;
                    if (!pass_p2) err_q <= sat_inc(err_q);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_check_done = done_q;
    assign bus.o_check_ok   = ok_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_err_cnt    = err_q;

endmodule
